vga_fetch_arbiter: RTL

- Shares one single-port, 1-cycle-read-latency framebuffer RAM between two requesters.
- Requester 1 is the VGA scan-out line prefetch: a burst of LINE_WORDS reads into the line buffer during blanking.
- Requester 2 is a host port doing single-word read/write with req/ack.
- Line fetch has priority, so scan-out never starves; host traffic fills idle RAM cycles.

---
 rtl/vga_fetch_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_fetch_arbiter.sv
// Framebuffer RAM arbiter: VGA line prefetch (priority) vs. single-word host port.
// Optional HOST_INTERLEAVE_EN gives the host one slot every SLICE line reads.
module vga_fetch_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int LINE_WORDS = 100,
  parameter int LB_AW      = 7,
  parameter int SLICE      = 8
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_line_req,
  input  logic [AW-1:0]    i_line_base,
  output logic             o_line_busy,
  output logic             o_line_overrun,
  output logic             o_lb_we,
  output logic [LB_AW-1:0] o_lb_addr,
  output logic [DW-1:0]    o_lb_data,
  input  logic             i_host_req,
  input  logic             i_host_we,
  input  logic [AW-1:0]    i_host_addr,
  input  logic [DW-1:0]    i_host_wdata,
  output logic             o_host_ack,
  output logic [DW-1:0]    o_host_rdata,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [DW-1:0]    o_mem_wdata,
  input  logic [DW-1:0]    i_mem_rdata
);

  // state names the owner of the RAM access issued in the current cycle
  typedef enum logic [1:0] {IDLE, LINE, HOST} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LB_AW-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             host_rd_q, host_rd_d;
  logic             busy_d, ovr_d, lb_we_d, ack_d;
  logic [LB_AW-1:0] lb_addr_d;
  logic             mem_en_d, mem_we_d;
  logic [AW-1:0]    mem_addr_d;
  logic [DW-1:0]    mem_wdata_d;
  logic             line_ok, host_ok, host_go, last;

`ifdef HOST_INTERLEAVE_EN
  localparam int SLW = (SLICE > 1) ? $clog2(SLICE + 1) : 1;
  logic [SLW-1:0] sl_q, sl_d;
  logic           resume_q, resume_d, slice_hit;
  assign slice_hit = (sl_q == SLW'(SLICE - 1));
`else
  logic unused_slice;
  assign unused_slice = |SLICE;
`endif

  assign line_ok = i_line_req && !o_line_busy && !pend_q;
  // ack cycle may still see the old request held high; never re-issue it
  assign host_ok = i_host_req && !o_host_ack;
  assign last    = (idx_q == LB_AW'(LINE_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    host_rd_d   = 1'b0;
    ovr_d       = i_line_req && (o_line_busy || pend_q);
    lb_we_d     = 1'b0;
    lb_addr_d   = '0;
    ack_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    host_go     = 1'b0;
`ifdef HOST_INTERLEAVE_EN
    resume_d    = resume_q;
    sl_d        = sl_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q || line_ok) begin
          state_d    = LINE;
          base_d     = pend_q ? base_q : i_line_base;
          idx_d      = '0;
          pend_d     = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = pend_q ? base_q : i_line_base;
`ifdef HOST_INTERLEAVE_EN
          sl_d       = '0;
`endif
        end else if (host_ok) begin
          host_go = 1'b1;
        end
      end
      LINE: begin
        lb_we_d   = 1'b1;
        lb_addr_d = idx_q;
        if (last) begin
          state_d = IDLE;
          host_go = host_ok;
        end else begin
          idx_d = idx_q + 1'b1;
`ifdef HOST_INTERLEAVE_EN
          sl_d  = slice_hit ? sl_q : sl_q + 1'b1;
          if (slice_hit && host_ok) begin
            host_go  = 1'b1;
            resume_d = 1'b1;
            sl_d     = '0;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = base_q + AW'(idx_q + 1'b1);
          end
`else
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + AW'(idx_q + 1'b1);
`endif
        end
      end
      HOST: begin
        ack_d     = 1'b1;
        host_rd_d = !o_mem_we;
        state_d   = IDLE;
`ifdef HOST_INTERLEAVE_EN
        if (resume_q) begin
          state_d    = LINE;
          resume_d   = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + AW'(idx_q);
        end else if (line_ok) begin
          pend_d = 1'b1;
          base_d = i_line_base;
        end
`else
        if (line_ok) begin
          pend_d = 1'b1;
          base_d = i_line_base;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (host_go) begin
      state_d     = HOST;
      mem_en_d    = 1'b1;
      mem_we_d    = i_host_we;
      mem_addr_d  = i_host_addr;
      mem_wdata_d = i_host_wdata;
    end
`ifdef HOST_INTERLEAVE_EN
    busy_d = (state_d == LINE) || lb_we_d || pend_d || resume_d;
`else
    busy_d = (state_d == LINE) || lb_we_d || pend_d;
`endif
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q        <= IDLE;
      base_q         <= '0;
      idx_q          <= '0;
      pend_q         <= 1'b0;
      host_rd_q      <= 1'b0;
      o_line_busy    <= 1'b0;
      o_line_overrun <= 1'b0;
      o_lb_we        <= 1'b0;
      o_lb_addr      <= '0;
      o_host_ack     <= 1'b0;
      o_mem_en       <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
`ifdef HOST_INTERLEAVE_EN
      resume_q       <= 1'b0;
      sl_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      idx_q          <= idx_d;
      pend_q         <= pend_d;
      host_rd_q      <= host_rd_d;
      o_line_busy    <= busy_d;
      o_line_overrun <= ovr_d;
      o_lb_we        <= lb_we_d;
      o_lb_addr      <= lb_addr_d;
      o_host_ack     <= ack_d;
      o_mem_en       <= mem_en_d;
      o_mem_we       <= mem_we_d;
      o_mem_addr     <= mem_addr_d;
      o_mem_wdata    <= mem_wdata_d;
`ifdef HOST_INTERLEAVE_EN
      resume_q       <= resume_d;
      sl_q           <= sl_d;
`endif
    end
  end

  // RAM output register is the data stage; qualify it so idle/reset reads as 0
  assign o_lb_data    = o_lb_we ? i_mem_rdata : '0;
  assign o_host_rdata = (o_host_ack && host_rd_q) ? i_mem_rdata : '0;

endmodule
